// File: rtl/uart_cmd_rx_pkg.sv
// Shared constants for the UART command receiver: header tag, FSM state
// codes, the command record and a header-match helper.
package uart_cmd_rx_pkg;

    // Opcode width, shared with the downstream ALU.
    localparam int OPCODE_W = 3;

    // Upper five bits every command header byte must carry.
    localparam logic [4:0] CMD_HDR_TAG = 5'b10100;

    // Byte FSM state codes.
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_START = 2'd1;
    localparam logic [1:0] ST_DATA  = 2'd2;
    localparam logic [1:0] ST_STOP  = 2'd3;

    // Frame FSM state codes.
    localparam logic [1:0] FR_HDR   = 2'd0;
    localparam logic [1:0] FR_ARG_A = 2'd1;
    localparam logic [1:0] FR_ARG_B = 2'd2;

    // One decoded command as presented to the head FSM.
    typedef struct packed {
        logic [OPCODE_W-1:0] opcode;
        logic [7:0]          a;
        logic [7:0]          b;
    } cmd_t;

    // True when a received byte is a valid command header.
    function automatic logic is_cmd_header(input logic [7:0] data);
        return data[7:3] == CMD_HDR_TAG;
    endfunction

endpackage

// File: rtl/uart_cmd_rx_if.sv
// Command handshake between the UART command receiver (master) and the
// head FSM (slave).
interface uart_cmd_rx_if;
    import uart_cmd_rx_pkg::*;

    logic                cmd_valid;
    logic                cmd_ready;
    logic [OPCODE_W-1:0] cmd_opcode;
    logic [7:0]          cmd_a;
    logic [7:0]          cmd_b;

    modport master (
        output cmd_valid,
        output cmd_opcode,
        output cmd_a,
        output cmd_b,
        input  cmd_ready
    );

    modport slave (
        input  cmd_valid,
        input  cmd_opcode,
        input  cmd_a,
        input  cmd_b,
        output cmd_ready
    );

endinterface

// File: rtl/uart_rx_byte.sv
// 8N1 UART byte receiver: two-flop synchroniser, start-bit glitch filter,
// mid-bit sampling, stop-bit check. Counterpart of the UART_TX block.
module uart_rx_byte
    import uart_cmd_rx_pkg::*;
#(
    parameter int CLKS_PER_BIT = 1250
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       i_rx,
    output logic       o_byte_valid,
    output logic [7:0] o_byte_data,
    output logic       o_frame_err,
    output logic       o_start
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] HALF_M1 = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] BIT_M1  = CNT_W'(CLKS_PER_BIT - 1);

    logic             r_rx_meta;
    logic             r_rx_sync;
    logic [1:0]       r_state;
    logic [CNT_W-1:0] r_baud;
    logic [2:0]       r_bit_idx;
    logic [7:0]       r_shift;
    logic             r_byte_valid;
    logic             r_frame_err;

    // Bring the asynchronous line into the clock domain.
    // NOTE: the synchroniser resets to 1 so a reset does not look like a start edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rx_meta <= 1'b1;
            r_rx_sync <= 1'b1;
        end else begin
            r_rx_meta <= i_rx;
            r_rx_sync <= r_rx_meta;
        end
    end

    // Byte FSM: find the start bit, sample data mid-bit, check the stop bit.
    // NOTE: state is updated with non-blocking assignments so every branch sees pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= ST_IDLE;
            r_baud       <= '0;
            r_bit_idx    <= '0;
            r_shift      <= '0;
            r_byte_valid <= 1'b0;
            r_frame_err  <= 1'b0;
        end else begin
            r_byte_valid <= 1'b0;
            r_frame_err  <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (!r_rx_sync) begin
                        r_state <= ST_START;
                        r_baud  <= '0;
                    end
                end
                ST_START: begin
                    if (r_baud == HALF_M1) begin
                        r_baud    <= '0;
                        r_bit_idx <= '0;
                        // A line back high at mid-start was only a glitch.
                        r_state   <= r_rx_sync ? ST_IDLE : ST_DATA;
                    end else begin
                        r_baud <= r_baud + 1'b1;
                    end
                end
                ST_DATA: begin
                    if (r_baud == BIT_M1) begin
                        r_baud  <= '0;
                        r_shift <= {r_rx_sync, r_shift[7:1]};
                        if (r_bit_idx == 3'd7) begin
                            r_state <= ST_STOP;
                        end else begin
                            r_bit_idx <= r_bit_idx + 1'b1;
                        end
                    end else begin
                        r_baud <= r_baud + 1'b1;
                    end
                end
                ST_STOP: begin
                    if (r_baud == BIT_M1) begin
                        r_baud  <= '0;
                        r_state <= ST_IDLE;
                        if (r_rx_sync) begin
                            r_byte_valid <= 1'b1;
                        end else begin
                            r_frame_err <= 1'b1;
                        end
                    end else begin
                        r_baud <= r_baud + 1'b1;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign o_byte_valid = r_byte_valid;
    assign o_byte_data  = r_shift;
    assign o_frame_err  = r_frame_err;
    assign o_start      = (r_state == ST_IDLE) && !r_rx_sync;

endmodule

// File: rtl/uart_cmd_rx.sv
// UART command receiver: frames [HDR, A, B] byte triples into commands and
// hands them to the head FSM over a valid/ready handshake. Drops bad headers,
// framing errors and stalled frames.
module uart_cmd_rx
    import uart_cmd_rx_pkg::*;
#(
    parameter int CLKS_PER_BIT = 1250,
    parameter int TIMEOUT_BITS = 20
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_rx,
    uart_cmd_rx_if.master cmd,
    output logic          o_frame_err,
    output logic          o_overrun
);

    localparam int TO_LIMIT_INT = TIMEOUT_BITS * CLKS_PER_BIT;
    localparam int TO_W         = $clog2(TO_LIMIT_INT + 1);
    localparam logic [TO_W-1:0] TO_LIMIT = TO_W'(TO_LIMIT_INT);

    logic                w_byte_valid;
    logic [7:0]          w_byte_data;
    logic                w_frame_err;
    logic                w_start;
    logic                w_frame_done;
    logic                w_timeout;

    logic [1:0]          r_frame_state;
    logic [OPCODE_W-1:0] r_opcode;
    logic [7:0]          r_a;
    logic [TO_W-1:0]     r_idle_cnt;
    cmd_t                r_cmd;
    logic                r_cmd_valid;
    logic                r_overrun;

    uart_rx_byte #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_rx_byte (
        .clk         (clk),
        .rst         (rst),
        .i_rx        (i_rx),
        .o_byte_valid(w_byte_valid),
        .o_byte_data (w_byte_data),
        .o_frame_err (w_frame_err),
        .o_start     (w_start)
    );

    assign w_frame_done = w_byte_valid && (r_frame_state == FR_ARG_B);
    assign w_timeout    = (r_frame_state != FR_HDR) && (r_idle_cnt == TO_LIMIT);

    // Frame FSM: collect header, operand a, operand b.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_frame_state <= FR_HDR;
            r_opcode      <= '0;
            r_a           <= '0;
        end else if (w_frame_err) begin
            r_frame_state <= FR_HDR;
        end else if (w_byte_valid) begin
            case (r_frame_state)
                FR_HDR: begin
                    if (is_cmd_header(w_byte_data)) begin
                        r_opcode      <= w_byte_data[OPCODE_W-1:0];
                        r_frame_state <= FR_ARG_A;
                    end
                end
                FR_ARG_A: begin
                    r_a           <= w_byte_data;
                    r_frame_state <= FR_ARG_B;
                end
                default: r_frame_state <= FR_HDR;
            endcase
        end else if (w_timeout) begin
            r_frame_state <= FR_HDR;
        end
    end

    // Inter-byte idle counter; only runs while a frame is partially received.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_idle_cnt <= '0;
        end else if ((r_frame_state == FR_HDR) || w_byte_valid || w_start) begin
            r_idle_cnt <= '0;
        end else if (r_idle_cnt != TO_LIMIT) begin
            r_idle_cnt <= r_idle_cnt + 1'b1;
        end
    end

    // Output handshake: load on frame completion, clear on accept, flag overrun.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cmd       <= '0;
            r_cmd_valid <= 1'b0;
            r_overrun   <= 1'b0;
        end else begin
            r_overrun <= 1'b0;
            if (w_frame_done) begin
                // Accepting this cycle frees the slot, so the new command loads with no bubble.
                if (!r_cmd_valid || cmd.cmd_ready) begin
                    r_cmd       <= '{opcode: r_opcode, a: r_a, b: w_byte_data};
                    r_cmd_valid <= 1'b1;
                end else begin
                    r_overrun <= 1'b1;
                end
            end else if (r_cmd_valid && cmd.cmd_ready) begin
                r_cmd_valid <= 1'b0;
            end
        end
    end

    assign cmd.cmd_valid  = r_cmd_valid;
    assign cmd.cmd_opcode = r_cmd.opcode;
    assign cmd.cmd_a      = r_cmd.a;
    assign cmd.cmd_b      = r_cmd.b;
    assign o_frame_err    = w_frame_err;
    assign o_overrun      = r_overrun;

endmodule

// File: tb/tb_uart_cmd_rx.sv
// Scoreboard bench for uart_cmd_rx: a frame-level model predicts commands,
// framing-error and overrun pulses; a monitor compares at every falling edge.
module tb_uart_cmd_rx;
    import uart_cmd_rx_pkg::*;

    localparam int CPB = 16;
    localparam int TOB = 20;

    typedef struct {
        logic [2:0] op;
        logic [7:0] a;
        logic [7:0] b;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic rx  = 1'b1;
    logic frame_err;
    logic overrun;

    int errors = 0;
    int checks = 0;
    exp_t exp_q[$];
    logic [7:0] partial[$];
    int exp_ferr = 0;
    int exp_ovr  = 0;
    int seen_ferr = 0;
    int seen_ovr  = 0;

    uart_cmd_rx_if u_if ();

    uart_cmd_rx #(
        .CLKS_PER_BIT(CPB),
        .TIMEOUT_BITS(TOB)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .i_rx       (rx),
        .cmd        (u_if),
        .o_frame_err(frame_err),
        .o_overrun  (overrun)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, req);
        end
    endtask

    // Monitor: compare presented commands against the scoreboard head.
    always @(negedge clk) begin
        if (!rst) begin
            if (exp_q.size() == 0) begin
                check("idle_valid", u_if.cmd_valid, 0);
            end else if (u_if.cmd_valid) begin
                check("cmd_opcode", u_if.cmd_opcode, exp_q[0].op);
                check("cmd_a", u_if.cmd_a, exp_q[0].a);
                check("cmd_b", u_if.cmd_b, exp_q[0].b);
                if (u_if.cmd_ready) void'(exp_q.pop_front());
            end
            if (frame_err) seen_ferr++;
            if (overrun) seen_ovr++;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) tick();
    endtask

    // Frame-level reference: what one received byte does to the command stream.
    task automatic model_byte(input logic [7:0] d, input bit stop_ok, input bit long_gap);
        exp_t e;
        if (!stop_ok) begin
            partial.delete();
            exp_ferr++;
            return;
        end
        if (long_gap) partial.delete();
        if (partial.size() == 0) begin
            if (d[7:3] == 5'b10100) partial.push_back(d);
        end else begin
            partial.push_back(d);
            if (partial.size() == 3) begin
                if (exp_q.size() > 0 && !u_if.cmd_ready) begin
                    exp_ovr++;
                end else begin
                    e.op = partial[0][2:0];
                    e.a  = partial[1];
                    e.b  = partial[2];
                    exp_q.push_back(e);
                end
                partial.delete();
            end
        end
    endtask

    task automatic send_byte(input logic [7:0] d, input bit stop_ok, input int gap_bits);
        rx = 1'b1;
        idle(gap_bits * CPB);
        model_byte(d, stop_ok, gap_bits > TOB);
        rx = 1'b0;
        idle(CPB);
        for (int i = 0; i < 8; i++) begin
            rx = d[i];
            idle(CPB);
        end
        if (stop_ok) begin
            rx = 1'b1;
            idle(CPB);
        end else begin
            // Low long enough to be sampled mid-stop, then back to idle.
            rx = 1'b0;
            idle(CPB - 4);
            rx = 1'b1;
            idle(4);
        end
    endtask

    task automatic send_frame(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b,
                              input int gap_bits);
        send_byte({5'b10100, op}, 1'b1, gap_bits);
        send_byte(a, 1'b1, 0);
        send_byte(b, 1'b1, 0);
    endtask

    task automatic wait_valid(input int budget);
        for (int i = 0; i < budget && !u_if.cmd_valid; i++) tick();
        check("valid_wait", u_if.cmd_valid, 1);
    endtask

    task automatic drain(input string name);
        for (int i = 0; i < 200 && exp_q.size() != 0; i++) tick();
        idle(2 * CPB);
        check(name, exp_q.size(), 0);
        check({name, "_frame_err_count"}, seen_ferr, exp_ferr);
        check({name, "_overrun_count"}, seen_ovr, exp_ovr);
    endtask

    task automatic check_all_zero(input string name);
        check({name, "_valid"}, u_if.cmd_valid, 0);
        check({name, "_opcode"}, u_if.cmd_opcode, 0);
        check({name, "_a"}, u_if.cmd_a, 0);
        check({name, "_b"}, u_if.cmd_b, 0);
        check({name, "_frame_err"}, frame_err, 0);
        check({name, "_overrun"}, overrun, 0);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not complete, errors=%0d", errors);
        $fatal(1);
    end

    initial begin
        bit prev_bad;
        logic [7:0] d;
        bit ok;
        int gap;

        u_if.cmd_ready = 1'b0;
        rx  = 1'b1;
        rst = 1'b1;
        idle(3);
        check_all_zero("reset");
        rst = 1'b0;
        idle(4);

        // Basic frame, held until accepted, cleared the cycle after accept.
        send_frame(3'd2, 8'h05, 8'h03, 1);
        wait_valid(64);
        idle(20);
        check("t1_held_valid", u_if.cmd_valid, 1);
        u_if.cmd_ready = 1'b1;
        tick();
        check("t1_cleared", u_if.cmd_valid, 0);
        drain("t1");

        // Framing error drops the partial frame; the next frame decodes.
        send_byte(8'hA1, 1'b1, 1);
        send_byte(8'h07, 1'b0, 0);
        send_frame(3'd0, 8'h01, 8'h02, 2);
        drain("t2");

        // Non-header byte ignored.
        send_byte(8'h42, 1'b1, 1);
        send_frame(3'd4, 8'h10, 8'h20, 0);
        drain("t3");

        // Short low glitch: no byte, no framing error, receiver still usable.
        rx = 1'b0;
        idle(4);
        rx = 1'b1;
        idle(3 * CPB);
        check("t4_no_frame_err", seen_ferr, exp_ferr);
        send_frame(3'd3, 8'h5A, 8'hC3, 0);
        drain("t4");

        // Stalled frame times out; following frame decodes alone.
        send_byte(8'hA3, 1'b1, 1);
        send_byte(8'h11, 1'b1, 0);
        send_frame(3'd5, 8'h01, 8'h02, 21);
        drain("t5");

        // Overrun: second frame lost while the first is still pending.
        u_if.cmd_ready = 1'b0;
        send_frame(3'd1, 8'h01, 8'h01, 1);
        send_frame(3'd2, 8'h02, 8'h02, 1);
        idle(2 * CPB);
        check("t6_overrun_count", seen_ovr, exp_ovr);
        check("t6_held_valid", u_if.cmd_valid, 1);
        check("t6_held_opcode", u_if.cmd_opcode, 1);
        check("t6_held_a", u_if.cmd_a, 1);
        check("t6_held_b", u_if.cmd_b, 1);

        // Reset in the middle of byte A's data bits.
        send_byte(8'hA7, 1'b1, 1);
        rx = 1'b0;
        idle(CPB);
        rx = 1'b1;
        idle(3 * CPB);
        rst = 1'b1;
        exp_q.delete();
        partial.delete();
        #1;
        check_all_zero("midbyte_reset");
        idle(3);
        rst = 1'b0;
        idle(4);
        u_if.cmd_ready = 1'b1;
        send_frame(3'd6, 8'h33, 8'h44, 1);
        drain("post_reset");

        // Randomized byte stream: headers, junk, bad stops, short and long gaps.
        prev_bad = 1'b0;
        for (int n = 0; n < 60; n++) begin
            if ($urandom_range(0, 9) < 4) d = {5'b10100, 3'($urandom_range(0, 7))};
            else d = 8'($urandom);
            ok  = ($urandom_range(0, 9) != 0);
            gap = $urandom_range(0, 3);
            if ($urandom_range(0, 19) == 0) gap = 25;
            if (prev_bad && gap < 2) gap = 2;
            send_byte(d, ok, gap);
            prev_bad = !ok;
        end
        drain("random");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
